instr_sequencer: RTL and testbench

//  Multi-cycle FSM that sequences the single-issue MIPS-subset datapath through FETCH, DECODE, EXEC, MEM and WB.
//  It takes the decoded control signals (PCcontrol, MemWrite, MemToReg, RegWrite, Link) from the instruction decoder.
//  It emits per-cycle enables: IR load, ALU result latch, memory requests, register-file write and PC update.
//  It handles imem/dmem handshakes with a wait timeout, halt/resume, and a retired-instruction counter.

---
 rtl/instr_sequencer.sv | 170 +++++++++++++++++
 tb/tb_instr_sequencer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_sequencer.sv
// instr_sequencer: multi-cycle control FSM for a single-issue MIPS-subset datapath.
// Walks FETCH -> DECODE -> EXEC -> (MEM) -> (WB) and emits per-cycle datapath
// enables. Memory waits are bounded by a timeout, HALT parks the machine until
// start, and a counter tracks retired instructions.
module instr_sequencer #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             halt_instr,
    input  logic [1:0]       pc_control,
    input  logic             mem_write,
    input  logic             mem_to_reg,
    input  logic             reg_write,
    input  logic             link,
    input  logic             imem_ack,
    input  logic             dmem_ack,
    output logic             imem_req,
    output logic             ir_we,
    output logic             alu_latch,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             rf_we,
    output logic             pc_we,
    output logic [1:0]       pc_sel,
    output logic             busy,
    output logic             halted,
    output logic             err,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6,
        S_ERR    = 3'd7
    } state_t;

    // Wide enough to hold MEM_TIMEOUT-1; a disabled timeout still gets one bit.
    localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);
    localparam bit TIMEOUT_EN = (MEM_TIMEOUT != 0);

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt;
    logic              retire;
    logic              waiting;
    logic              timeout_hit;

    // A request that has waited its last allowed cycle without ack gives up.
    assign timeout_hit = TIMEOUT_EN && (wait_cnt == WAIT_LAST);
    assign waiting     = ((state_q == S_FETCH) && !imem_ack) ||
                         ((state_q == S_MEM)   && !dmem_ack);

    assign state  = state_q;
    assign busy   = (state_q != S_IDLE) && (state_q != S_HALT) && (state_q != S_ERR);
    assign halted = (state_q == S_HALT);
    assign err    = (state_q == S_ERR);

    // Next-state and per-cycle strobes, decoded from the current state and inputs.
    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves it unassigned (no latches).
        state_d   = state_q;
        imem_req  = 1'b0;
        ir_we     = 1'b0;
        alu_latch = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        rf_we     = 1'b0;
        pc_we     = 1'b0;
        pc_sel    = 2'd0;
        retire    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_FETCH;
            end
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    ir_we   = 1'b1;
                    state_d = S_DECODE;
                end else if (timeout_hit) begin
                    state_d = S_ERR;
                end
            end
            S_DECODE: begin
                if (halt_instr) begin
                    // Advance the PC past HALT so resume continues with the next instruction.
                    pc_we   = 1'b1;
                    state_d = S_HALT;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                alu_latch = 1'b1;
                if (mem_write || mem_to_reg) begin
                    state_d = S_MEM;
                end else if (reg_write || link) begin
                    state_d = S_WB;
                end else begin
                    // Branch / jump completes here.
                    pc_we   = 1'b1;
                    pc_sel  = pc_control;
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = mem_write;
                if (dmem_ack) begin
                    if (mem_to_reg) begin
                        state_d = S_WB;
                    end else begin
                        pc_we   = 1'b1;
                        pc_sel  = pc_control;
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end
                end else if (timeout_hit) begin
                    state_d = S_ERR;
                end
            end
            S_WB: begin
                rf_we   = 1'b1;
                pc_we   = 1'b1;
                pc_sel  = pc_control;
                retire  = 1'b1;
                state_d = S_FETCH;
            end
            S_HALT: begin
                if (start) state_d = S_FETCH;
            end
            S_ERR: begin
                state_d = S_ERR;
            end
            default: begin
                state_d = S_ERR;
            end
        endcase
    end

    // State, wait counter and retired counter; reset is synchronous.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (!rst_n) begin
            state_q  <= S_IDLE;
            wait_cnt <= '0;
            retired  <= '0;
        end else begin
            state_q <= state_d;
            if ((state_d != state_q) && ((state_d == S_FETCH) || (state_d == S_MEM))) begin
                wait_cnt <= '0;
            end else if (waiting) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if (retire) retired <= retired + 1'b1;
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed testbench for instr_sequencer: walks add, lw, sw, beq, jal, halt,
// fetch timeout, reset mid-access and retired-counter wrap with hand-derived
// expected values.
module tb_instr_sequencer;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       halt_instr;
    logic [1:0] pc_control;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic       link;
    logic       imem_ack;
    logic       dmem_ack;
    logic       imem_req;
    logic       ir_we;
    logic       alu_latch;
    logic       dmem_req;
    logic       dmem_we;
    logic       rf_we;
    logic       pc_we;
    logic [1:0] pc_sel;
    logic       busy;
    logic       halted;
    logic       err;
    logic [2:0] state;
    logic [3:0] retired;

    logic [11:0] outs;
    int          tests_run;
    int          tests_failed;
    int          n_req;

    assign outs = {imem_req, ir_we, alu_latch, dmem_req, dmem_we, rf_we, pc_we,
                   pc_sel, busy, halted, err};

    instr_sequencer #(.MEM_TIMEOUT(16), .CNT_W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .halt_instr (halt_instr),
        .pc_control (pc_control),
        .mem_write  (mem_write),
        .mem_to_reg (mem_to_reg),
        .reg_write  (reg_write),
        .link       (link),
        .imem_ack   (imem_ack),
        .dmem_ack   (dmem_ack),
        .imem_req   (imem_req),
        .ir_we      (ir_we),
        .alu_latch  (alu_latch),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .rf_we      (rf_we),
        .pc_we      (pc_we),
        .pc_sel     (pc_sel),
        .busy       (busy),
        .halted     (halted),
        .err        (err),
        .state      (state),
        .retired    (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are changed 1ns after the edge, outputs sampled later.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tests_run = 0; tests_failed = 0;
        rst_n = 1'b0; start = 1'b0; halt_instr = 1'b0; pc_control = 2'd0;
        mem_write = 1'b0; mem_to_reg = 1'b0; reg_write = 1'b0; link = 1'b0;
        imem_ack = 1'b0; dmem_ack = 1'b0;

        // Reset state
        cyc(); cyc(); #1;
        check("rst_state",   {29'd0, state}, 32'd0);
        check("rst_outs",    {20'd0, outs},  32'd0);
        check("rst_retired", {28'd0, retired}, 32'd0);
        rst_n = 1'b1;

        // add: FETCH, DECODE, EXEC, WB
        start = 1'b1; imem_ack = 1'b1; reg_write = 1'b1; #1;
        check("idle_state", {29'd0, state}, 32'd0);
        cyc(); start = 1'b0; #1;
        check("add_fetch",  {state, imem_req, ir_we}, {3'd1, 1'b1, 1'b1});
        cyc(); #1;
        check("add_decode", {state, pc_we}, {3'd2, 1'b0});
        cyc(); #1;
        check("add_exec",   {state, alu_latch, pc_we}, {3'd3, 1'b1, 1'b0});
        cyc(); #1;
        check("add_wb",     {state, rf_we, pc_we, pc_sel, retired}, {3'd5, 1'b1, 1'b1, 2'd0, 4'd0});
        cyc(); #1;
        check("add_retired", {state, retired}, {3'd1, 4'd1});

        // lw with dmem_ack on the 4th MEM cycle
        mem_to_reg = 1'b1; dmem_ack = 1'b0;
        cyc(); cyc(); cyc();
        n_req = 0;
        for (int i = 0; i < 4; i++) begin
            dmem_ack = (i == 3);
            #1;
            if (state == 3'd4 && dmem_req && !dmem_we && !rf_we) n_req++;
            cyc();
        end
        check("lw_req_cycles", n_req, 4);
        dmem_ack = 1'b0; #1;
        check("lw_wb", {state, rf_we, pc_we, pc_sel}, {3'd5, 1'b1, 1'b1, 2'd0});
        cyc(); #1;
        check("lw_retired", {state, retired}, {3'd1, 4'd2});

        // sw: MEM completes the instruction, no WB
        mem_to_reg = 1'b0; reg_write = 1'b0; mem_write = 1'b1; dmem_ack = 1'b1;
        cyc(); cyc(); cyc(); #1;
        check("sw_mem", {state, dmem_req, dmem_we, pc_we, pc_sel, rf_we},
                        {3'd4, 1'b1, 1'b1, 1'b1, 2'd0, 1'b0});
        cyc(); #1;
        check("sw_retired", {state, retired}, {3'd1, 4'd3});

        // beq: completes in EXEC
        mem_write = 1'b0; dmem_ack = 1'b0; pc_control = 2'd1;
        cyc(); cyc(); #1;
        check("beq_exec", {state, alu_latch, pc_we, pc_sel, rf_we},
                          {3'd3, 1'b1, 1'b1, 2'd1, 1'b0});
        cyc(); #1;
        check("beq_retired", {state, retired}, {3'd1, 4'd4});

        // jal: link forces WB with pc_sel=3
        pc_control = 2'd3; link = 1'b1;
        cyc(); cyc(); #1;
        check("jal_exec", {state, pc_we}, {3'd3, 1'b0});
        cyc(); #1;
        check("jal_wb", {state, rf_we, pc_we, pc_sel}, {3'd5, 1'b1, 1'b1, 2'd3});
        cyc(); #1;
        check("jal_retired", {state, retired}, {3'd1, 4'd5});

        // HALT at DECODE: pc_sel forced to 0, not retired
        link = 1'b0; halt_instr = 1'b1;
        cyc(); #1;
        check("halt_decode", {state, pc_we, pc_sel}, {3'd2, 1'b1, 2'd0});
        cyc(); #1;
        check("halt_state", {state, halted, busy, retired}, {3'd6, 1'b1, 1'b0, 4'd5});
        cyc(); #1;
        check("halt_hold", {29'd0, state}, 32'd6);
        start = 1'b1;
        cyc(); start = 1'b0; halt_instr = 1'b0; pc_control = 2'd1; imem_ack = 1'b0; #1;
        check("resume_fetch", {state, busy, halted}, {3'd1, 1'b1, 1'b0});

        // Late ack on the 16th FETCH cycle still proceeds
        n_req = 0;
        for (int i = 0; i < 15; i++) begin
            if (i > 0) #1;
            if (state == 3'd1 && imem_req) n_req++;
            cyc();
        end
        check("late_req_cycles", n_req, 15);
        imem_ack = 1'b1; #1;
        check("late_ack_fetch", {state, ir_we}, {3'd1, 1'b1});
        cyc(); imem_ack = 1'b0; #1;
        check("late_ack_decode", {state, err}, {3'd2, 1'b0});
        cyc(); cyc(); #1;
        check("beq2_retired", {state, retired}, {3'd1, 4'd6});

        // Fetch timeout: 16 unacknowledged cycles -> ERR
        n_req = 0;
        for (int i = 0; i < 16; i++) begin
            #1;
            if (state == 3'd1 && imem_req) n_req++;
            cyc();
        end
        check("timeout_req_cycles", n_req, 16);
        #1;
        check("timeout_err", {state, err, imem_req, busy}, {3'd7, 1'b1, 1'b0, 1'b0});
        start = 1'b1;
        cyc(); cyc(); #1;
        check("err_sticky", {state, err}, {3'd7, 1'b1});
        start = 1'b0;

        // Reset clears ERR
        rst_n = 1'b0;
        cyc(); #1;
        check("err_reset", {13'd0, state, outs, retired}, 32'd0);
        rst_n = 1'b1;

        // beq then lw stalled in MEM, reset mid-access
        start = 1'b1; imem_ack = 1'b1; pc_control = 2'd1;
        cyc(); start = 1'b0;
        cyc(); cyc(); cyc(); #1;
        check("pre_reset_retired", {state, retired}, {3'd1, 4'd1});
        pc_control = 2'd0; mem_to_reg = 1'b1; reg_write = 1'b1; dmem_ack = 1'b0;
        cyc(); cyc(); cyc(); #1;
        check("mem_before_reset", {state, dmem_req}, {3'd4, 1'b1});
        rst_n = 1'b0;
        cyc(); #1;
        check("mid_reset", {13'd0, state, outs, retired}, 32'd0);
        rst_n = 1'b1; mem_to_reg = 1'b0; reg_write = 1'b0; pc_control = 2'd1;

        // 16 branch retires wrap the 4-bit counter
        start = 1'b1;
        cyc(); start = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            cyc(); cyc(); cyc(); #1;
            check($sformatf("wrap_retired_%0d", i), {28'd0, retired}, i % 16);
        end
        check("wrap_state", {29'd0, state}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
